// File: rtl/mau_gen2_if.sv
// Host-side signal bundle of the matrix arithmetic unit: instruction handshake,
// LOAD element stream, STORE element stream and status flags.
interface mau_gen2_if #(
    parameter int ELEM_W = 8
);
    logic [11:0]       host_instruction;
    logic              instr_valid;
    logic              instr_ready;
    logic [ELEM_W-1:0] data_in;
    logic              data_in_valid;
    logic [ELEM_W-1:0] data_out;
    logic              data_out_valid;
    logic              data_out_ready;
    logic              busy_flag;
    logic              done;
    logic              illegal;

    modport master (
        output host_instruction, instr_valid, data_in, data_in_valid, data_out_ready,
        input  instr_ready, data_out, data_out_valid, busy_flag, done, illegal
    );

    modport slave (
        input  host_instruction, instr_valid, data_in, data_in_valid, data_out_ready,
        output instr_ready, data_out, data_out_valid, busy_flag, done, illegal
    );
endinterface

// File: rtl/mau_gen2.sv
// Matrix arithmetic unit: NUM_BANKS banks of DxD elements with streaming LOAD/STORE,
// one-element-per-cycle element-wise ops and one-MAC-per-cycle matrix multiply.
module mau_gen2 #(
    parameter int MATRIX_DIM = 8,
    parameter int ELEM_W     = 8,
    parameter int NUM_BANKS  = 4,
    parameter int SAT_EN     = 0
) (
    input  logic      clk,
    input  logic      rst,
    mau_gen2_if.slave bus
);
    localparam int NE     = MATRIX_DIM * MATRIX_DIM;
    localparam int IDX_W  = $clog2(NE);
    localparam int MM_W   = $clog2(MATRIX_DIM);
    localparam int ACC_W  = 2 * ELEM_W + MM_W;
    localparam int BANK_W = $clog2(NUM_BANKS);

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LOAD   = 4'd1;
    localparam logic [3:0] OP_STORE  = 4'd2;
    localparam logic [3:0] OP_ADD    = 4'd3;
    localparam logic [3:0] OP_SUB    = 4'd4;
    localparam logic [3:0] OP_SHL    = 4'd5;
    localparam logic [3:0] OP_MUL    = 4'd6;
    localparam logic [3:0] OP_MATMUL = 4'd7;
    localparam logic [3:0] OP_COPY   = 4'd8;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STORE, S_EW, S_MM} state_t;

    state_t state, state_nxt;

    logic [ELEM_W-1:0] mem [NUM_BANKS][NE];

    logic [3:0]        opc;
    logic [1:0]        dst_f, src_a_f, src_b_f;
    logic              unused_instr_bits;
    logic              accept, instr_legal;
    logic              done_nxt, illegal_nxt, done_q, illegal_q;

    logic [3:0]        op_r;
    logic [BANK_W-1:0] dst_r, a_r, b_r;

    logic [IDX_W-1:0]  elem_cnt, elem_nxt;
    logic              elem_last;
    logic [MM_W-1:0]   i_cnt, j_cnt, k_cnt;
    logic              i_last, j_last, k_last, mm_last;
    logic [IDX_W-1:0]  addr_a, addr_b, addr_c;
    logic [ACC_W-1:0]  acc, mac_sum;
    logic [ELEM_W-1:0] rd_a, rd_b, ew_res;
    logic [ELEM_W-1:0] dout_q;
    logic              dov_q, st_prime;

    function automatic logic bank_ok(input logic [1:0] b);
        return 32'(b) < NUM_BANKS;
    endfunction

    function automatic logic [ELEM_W-1:0] clamp_hi(input logic [ACC_W-1:0] v);
        if (SAT_EN != 0 && |v[ACC_W-1:ELEM_W]) return {ELEM_W{1'b1}};
        return v[ELEM_W-1:0];
    endfunction

    function automatic logic [ELEM_W-1:0] clamp_sub(input logic [ELEM_W-1:0] a,
                                                    input logic [ELEM_W-1:0] b);
        if (SAT_EN != 0 && a < b) return '0;
        return a - b;
    endfunction

    function automatic logic [ELEM_W-1:0] ew_calc(input logic [3:0]        op,
                                                  input logic [ELEM_W-1:0] a,
                                                  input logic [ELEM_W-1:0] b);
        case (op)
            OP_ADD:  return clamp_hi(ACC_W'(a) + ACC_W'(b));
            OP_SUB:  return clamp_sub(a, b);
            OP_SHL:  return a << (32'(b) % 32'(ELEM_W));
            OP_MUL:  return clamp_hi(ACC_W'(a) * ACC_W'(b));
            default: return a;
        endcase
    endfunction

    assign opc               = bus.host_instruction[11:8];
    assign dst_f             = bus.host_instruction[7:6];
    assign src_a_f           = bus.host_instruction[5:4];
    assign src_b_f           = bus.host_instruction[3:2];
    assign unused_instr_bits = ^bus.host_instruction[1:0];
    assign accept            = bus.instr_valid && (state == S_IDLE);

    always_comb begin
        instr_legal = 1'b0;
        case (opc)
            OP_NOP:   instr_legal = 1'b1;
            OP_LOAD:  instr_legal = bank_ok(dst_f);
            OP_STORE: instr_legal = bank_ok(src_a_f);
            OP_COPY:  instr_legal = bank_ok(dst_f) && bank_ok(src_a_f);
            OP_ADD, OP_SUB, OP_SHL, OP_MUL:
                instr_legal = bank_ok(dst_f) && bank_ok(src_a_f) && bank_ok(src_b_f);
            OP_MATMUL:
                instr_legal = bank_ok(dst_f) && bank_ok(src_a_f) && bank_ok(src_b_f) &&
                              (dst_f != src_a_f) && (dst_f != src_b_f);
            default:  instr_legal = 1'b0;
        endcase
    end

    assign elem_nxt  = elem_cnt + 1'b1;
    assign elem_last = (elem_cnt == IDX_W'(NE - 1));
    assign i_last    = (i_cnt == MM_W'(MATRIX_DIM - 1));
    assign j_last    = (j_cnt == MM_W'(MATRIX_DIM - 1));
    assign k_last    = (k_cnt == MM_W'(MATRIX_DIM - 1));
    assign mm_last   = i_last && j_last && k_last;

    assign addr_a  = IDX_W'(i_cnt) * IDX_W'(MATRIX_DIM) + IDX_W'(k_cnt);
    assign addr_b  = IDX_W'(k_cnt) * IDX_W'(MATRIX_DIM) + IDX_W'(j_cnt);
    assign addr_c  = IDX_W'(i_cnt) * IDX_W'(MATRIX_DIM) + IDX_W'(j_cnt);
    assign mac_sum = acc + ACC_W'(mem[a_r][addr_a]) * ACC_W'(mem[b_r][addr_b]);

    assign rd_a   = mem[a_r][elem_cnt];
    assign rd_b   = mem[b_r][elem_cnt];
    assign ew_res = ew_calc(op_r, rd_a, rd_b);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_q    <= done_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (accept && instr_legal) begin
                    case (opc)
                        OP_LOAD:   state_nxt = S_LOAD;
                        OP_STORE:  state_nxt = S_STORE;
                        OP_MATMUL: state_nxt = S_MM;
                        OP_ADD, OP_SUB, OP_SHL, OP_MUL, OP_COPY: state_nxt = S_EW;
                        default:   state_nxt = S_IDLE;
                    endcase
                end
            S_LOAD:  if (bus.data_in_valid && elem_last) state_nxt = S_IDLE;
            S_STORE: if (dov_q && bus.data_out_ready && elem_last) state_nxt = S_IDLE;
            S_EW:    if (elem_last) state_nxt = S_IDLE;
            S_MM:    if (mm_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_flag   = (state != S_IDLE);
        bus.instr_ready = (state == S_IDLE);
        illegal_nxt     = accept && !instr_legal;
        done_nxt        = ((state != S_IDLE) && (state_nxt == S_IDLE)) ||
                          (accept && instr_legal && (opc == OP_NOP));
    end

    assign bus.done           = done_q;
    assign bus.illegal        = illegal_q;
    assign bus.data_out       = dout_q;
    assign bus.data_out_valid = dov_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            op_r  <= opc;
            dst_r <= BANK_W'(dst_f);
            a_r   <= BANK_W'(src_a_f);
            b_r   <= BANK_W'(src_b_f);
        end
    end

    // STORE waits one priming cycle so the first element appears two edges after acceptance
    always_ff @(posedge clk) begin
        if (!rst) begin
            elem_cnt <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
            acc      <= '0;
            dout_q   <= '0;
            dov_q    <= 1'b0;
            st_prime <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    elem_cnt <= '0;
                    i_cnt    <= '0;
                    j_cnt    <= '0;
                    k_cnt    <= '0;
                    acc      <= '0;
                    st_prime <= 1'b0;
                end
                S_LOAD: if (bus.data_in_valid) elem_cnt <= elem_nxt;
                S_EW:   elem_cnt <= elem_nxt;
                S_STORE: begin
                    if (!dov_q) begin
                        st_prime <= 1'b1;
                        if (st_prime) begin
                            dout_q <= rd_a;
                            dov_q  <= 1'b1;
                        end
                    end else if (bus.data_out_ready) begin
                        elem_cnt <= elem_nxt;
                        if (elem_last) dov_q  <= 1'b0;
                        else           dout_q <= mem[a_r][elem_nxt];
                    end
                end
                S_MM: begin
                    acc   <= k_last ? '0 : mac_sum;
                    k_cnt <= k_last ? '0 : k_cnt + 1'b1;
                    if (k_last) begin
                        j_cnt <= j_last ? '0 : j_cnt + 1'b1;
                        if (j_last) i_cnt <= i_last ? '0 : i_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bank contents survive reset; writes are suppressed on a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            case (state)
                S_LOAD:  if (bus.data_in_valid) mem[dst_r][elem_cnt] <= bus.data_in;
                S_EW:    mem[dst_r][elem_cnt] <= ew_res;
                S_MM:    if (k_last) mem[dst_r][addr_c] <= clamp_hi(mac_sum);
                default: ;
            endcase
        end
    end
endmodule
